// File: rtl/alu_div_seq_pkg.sv
// Shared constants for the RV32M divide sequencer: ALU opcodes, request op codes, FSM states.
package alu_div_seq_pkg;

    localparam int XLEN = 32;

    // ALU opcode map shared with the ALU and the decoder
    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0010;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0011;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0100;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
    localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OP_OR   = 4'b1000;
    localparam logic [3:0] ALU_OP_AND  = 4'b1001;

    typedef enum logic [1:0] {
        REQ_DIV  = 2'b00,
        REQ_DIVU = 2'b01,
        REQ_REM  = 2'b10,
        REQ_REMU = 2'b11
    } req_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CMP  = 3'd2,
        ST_SUB  = 3'd3,
        ST_FIX  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_div_seq_div_sign_fix.sv
// Absolute values of dividend/divisor and the result-negation flags for signed divide.
module div_sign_fix
    import alu_div_seq_pkg::*;
(
    input  logic            i_is_signed,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_abs_a,
    output logic [XLEN-1:0] o_abs_b,
    output logic            o_neg_q,
    output logic            o_neg_r
);

    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg = i_is_signed & i_a[XLEN-1];
    assign w_b_neg = i_is_signed & i_b[XLEN-1];

    // -0x80000000 wraps to itself, which is the correct unsigned magnitude
    assign o_abs_a = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign o_abs_b = w_b_neg ? (~i_b + 1'b1) : i_b;

    assign o_neg_q = w_a_neg ^ w_b_neg;
    assign o_neg_r = w_a_neg;

endmodule

// File: rtl/alu_div_seq.sv
// Restoring divider for DIV/DIVU/REM/REMU that borrows the execute-stage ALU.
// Optional result reuse for repeated operands: define ALU_DIV_REUSE_EN.
//
// state | meaning
// IDLE  | ready for a request
// PREP  | divide-by-zero / reuse check, take magnitudes, clear loop state
// CMP   | shift remainder, ALU SLTU decides whether to subtract
// SUB   | ALU SUB, commit remainder and quotient bit, advance counter
// FIX   | pick quotient or remainder, negate via ALU if required
// DONE  | hold response until consumer accepts
module alu_div_seq
    import alu_div_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            alu_sel_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_op_o,
    input  logic [XLEN-1:0] alu_res_i,
    output logic            busy_o
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_r;
    logic [4:0]      r_cnt;
    logic            r_sub;
    logic [XLEN-1:0] r_resp_data;

    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_neg_q;
    logic            w_neg_r;
    logic [XLEN-1:0] w_rs;
    logic [XLEN-1:0] w_fix_val;
    logic            w_fix_neg;
    logic            w_accept;
    logic            w_div0;
    logic            w_hit;

    div_sign_fix u_sign_fix (
        .i_is_signed (op_is_signed(r_op)),
        .i_a         (r_a),
        .i_b         (r_b),
        .o_abs_a     (w_abs_a),
        .o_abs_b     (w_abs_b),
        .o_neg_q     (w_neg_q),
        .o_neg_r     (w_neg_r)
    );

    assign w_accept  = req_valid_i & req_ready_o;
    assign w_div0    = (r_b == '0);
    assign w_rs      = {r_r[XLEN-2:0], r_q[XLEN-1]};
    assign w_fix_val = op_is_rem(r_op) ? r_r : r_q;
    assign w_fix_neg = op_is_rem(r_op) ? w_neg_r : w_neg_q;

`ifdef ALU_DIV_REUSE_EN
    logic            r_c_valid;
    logic            r_c_signed;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic [XLEN-1:0] r_c_q;
    logic [XLEN-1:0] r_c_r;

    assign w_hit = r_c_valid && (r_c_a == r_a) && (r_c_b == r_b)
                   && (r_c_signed == op_is_signed(r_op));

    // Both halves are stored so a DIV/REM pair on the same operands hits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_c_valid  <= 1'b0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_q      <= '0;
            r_c_r      <= '0;
        end else if ((r_state == ST_PREP && w_div0) || r_state == ST_FIX) begin
            r_c_valid  <= 1'b1;
            r_c_signed <= op_is_signed(r_op);
            r_c_a      <= r_a;
            r_c_b      <= r_b;
            if (r_state == ST_PREP) begin
                r_c_q <= '1;
                r_c_r <= r_a;
            end else begin
                r_c_q <= w_neg_q ? (~r_q + 1'b1) : r_q;
                r_c_r <= w_neg_r ? (~r_r + 1'b1) : r_r;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_sel_o   = 1'b0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = '0;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = (w_div0 || w_hit) ? ST_DONE : ST_CMP;
            ST_CMP: begin
                alu_sel_o   = 1'b1;
                alu_a_o     = w_rs;
                alu_b_o     = r_d;
                alu_op_o    = ALU_OP_SLTU;
                w_state_nxt = ST_SUB;
            end
            ST_SUB: begin
                alu_sel_o   = 1'b1;
                alu_a_o     = r_r;
                alu_b_o     = r_d;
                alu_op_o    = ALU_OP_SUB;
                w_state_nxt = (r_cnt == 5'd31) ? ST_FIX : ST_CMP;
            end
            ST_FIX: begin
                alu_sel_o   = 1'b1;
                alu_b_o     = w_fix_val;
                alu_op_o    = ALU_OP_SUB;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: if (resp_ready_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_sub       <= 1'b0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_op <= req_op_i;
                    r_a  <= req_a_i;
                    r_b  <= req_b_i;
                end
                ST_PREP: begin
                    if (w_div0)
                        r_resp_data <= op_is_rem(r_op) ? r_a : '1;
`ifdef ALU_DIV_REUSE_EN
                    else if (w_hit)
                        r_resp_data <= op_is_rem(r_op) ? r_c_r : r_c_q;
`endif
                    r_r   <= '0;
                    r_cnt <= '0;
                    r_q   <= w_abs_a;
                    r_d   <= w_abs_b;
                end
                ST_CMP: begin
                    // Carry-out of the shift forces a subtract; the ALU wrap is then exact
                    r_r   <= w_rs;
                    r_q   <= {r_q[XLEN-2:0], 1'b0};
                    r_sub <= r_r[XLEN-1] | ~alu_res_i[0];
                end
                ST_SUB: begin
                    if (r_sub) begin
                        r_r    <= alu_res_i;
                        r_q[0] <= 1'b1;
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_FIX: r_resp_data <= w_fix_neg ? alu_res_i : w_fix_val;
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (r_state == ST_IDLE) & ~rst_i;
    assign resp_valid_o = (r_state == ST_DONE);
    assign resp_data_o  = r_resp_data;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_div_seq.sv
// Randomized and directed bench for alu_div_seq against an arithmetic reference model.
module tb_alu_div_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic        alu_sel_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_res_i;
    logic        busy_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    alu_div_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .alu_sel_o    (alu_sel_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_op_o     (alu_op_o),
        .alu_res_i    (alu_res_i),
        .busy_o       (busy_o)
    );

    // Execute-stage ALU stand-in: only the two opcodes the sequencer uses
    always_comb begin
        alu_res_i = '0;
        case (alu_op_o)
            4'b0001: alu_res_i = alu_a_o - alu_b_o;
            4'b0100: alu_res_i = {31'b0, alu_a_o < alu_b_o};
            default: alu_res_i = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics, including divide-by-zero and signed overflow
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op[0] == 1'b0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready_o), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
        chk({tag, "_resp_data"}, resp_data_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_alu_sel"}, 32'(alu_sel_o), 32'd0);
        chk({tag, "_alu_a"}, alu_a_o, 32'd0);
        chk({tag, "_alu_b"}, alu_b_o, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op_o), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int          edges;
        int          sel_cnt;
        int          exp_lat;
        int          exp_sel;
        logic [31:0] exp;
        exp     = ref_result(op, a, b);
        exp_lat = (b == 32'd0) ? 2 : 67;
        exp_sel = (b == 32'd0) ? 0 : 65;
        @(negedge clk_i);
        chk("req_ready_idle", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        edges   = 1;
        sel_cnt = 0;
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        while (!resp_valid_o && edges < 200) begin
            sel_cnt += int'(alu_sel_o);
            @(posedge clk_i);
            #1;
            edges++;
        end
        chk("latency", 32'(edges), 32'(exp_lat));
        chk("resp_data", resp_data_o, exp);
        chk("alu_sel_cycles", 32'(sel_cnt), 32'(exp_sel));
        repeat (hold) begin
            @(posedge clk_i);
            #1;
            chk("hold_data", resp_data_o, exp);
            chk("hold_valid", 32'(resp_valid_o), 32'd1);
            chk("hold_req_ready", 32'(req_ready_o), 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b0;
        chk("req_ready_after_ack", 32'(req_ready_o), 32'd1);
        chk("valid_after_ack", 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_op_i     = 2'b00;
        req_a_i      = '0;
        req_b_i      = '0;
        resp_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        rst_i = 1'b0;

        run_op(2'b01, 32'd100, 32'd7, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(2'b01, 32'h1234, 32'd0, 0);
        run_op(2'b11, 32'h1234, 32'd0, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op(2'b00, 32'd100, 32'd7, 5);

        // Abort in the middle of iteration 10
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_op_i    = 2'b01;
        req_a_i     = 32'hFFFF_FFFF;
        req_b_i     = 32'd3;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        repeat (21) @(posedge clk_i);
        #1;
        chk("sel_mid_op", 32'(alu_sel_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_all_zero("mid_reset");
        rst_i = 1'b0;
        run_op(2'b01, 32'd9, 32'd3, 0);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_op(op, a, b, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
